// File: rtl/rob_dur_avg.sv
// Windowed mean (and optional max) of ROB residency samples on three channels,
// drained round-robin through one ready/valid slot. Define ROB_DUR_AVG_MAX_EN to build the max path.
module rob_dur_avg #(
  parameter int unsigned DUR_W  = 10,
  parameter int unsigned LOG2_N = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DUR_W-1:0] dur_dp,
  input  logic             dur_dp_vld,
  input  logic [DUR_W-1:0] dur_fast,
  input  logic             dur_fast_vld,
  input  logic [DUR_W-1:0] dur_slow,
  input  logic             dur_slow_vld,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [1:0]       out_ch,
  output logic [DUR_W-1:0] out_avg,
  output logic [DUR_W-1:0] out_max,
  output logic [2:0]       ovf
);

  localparam int unsigned SUM_W = DUR_W + LOG2_N;

  logic [2:0]        smp_vld;
  logic [DUR_W-1:0]  smp_dur    [3];
  logic [LOG2_N-1:0] cnt_q      [3];
  logic [SUM_W-1:0]  sum_q      [3];
  logic [SUM_W-1:0]  win_sum    [3];
  logic [DUR_W-1:0]  pend_avg_q [3];
  logic [2:0]        close;
  logic [2:0]        pend_q;
  logic [2:0]        ovf_q;
  logic [1:0]        rr_q;
  logic [2:0]        rr_idx;
  logic              slot_load;
  logic              found;
  logic [1:0]        gsel;
  logic [2:0]        grant;
  logic              out_vld_q;
  logic [1:0]        out_ch_q;
  logic [DUR_W-1:0]  out_avg_q;

  assign smp_vld    = {dur_slow_vld, dur_fast_vld, dur_dp_vld};
  assign smp_dur[0] = dur_dp;
  assign smp_dur[1] = dur_fast;
  assign smp_dur[2] = dur_slow;

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      close[c]   = smp_vld[c] && (cnt_q[c] == {LOG2_N{1'b1}});
      win_sum[c] = sum_q[c] + SUM_W'(smp_dur[c]);
    end
  end

  // Round-robin search starting at rr_q, wrapping slow -> dp.
  always_comb begin
    found  = 1'b0;
    gsel   = 2'd0;
    rr_idx = 3'd0;
    for (int i = 0; i < 3; i++) begin
      rr_idx = {1'b0, rr_q} + 3'(i);
      if (rr_idx >= 3'd3) rr_idx = rr_idx - 3'd3;
      if (!found && pend_q[rr_idx[1:0]]) begin
        found = 1'b1;
        gsel  = rr_idx[1:0];
      end
    end
    slot_load = !out_vld_q || out_rdy;
    grant     = '0;
    if (slot_load && found) grant[gsel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < 3; c++) begin
        cnt_q[c]      <= '0;
        sum_q[c]      <= '0;
        pend_avg_q[c] <= '0;
      end
      pend_q    <= '0;
      ovf_q     <= '0;
      rr_q      <= 2'd0;
      out_vld_q <= 1'b0;
      out_ch_q  <= 2'd0;
      out_avg_q <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (smp_vld[c]) begin
          if (close[c]) begin
            cnt_q[c] <= '0;
            sum_q[c] <= '0;
          end else begin
            cnt_q[c] <= cnt_q[c] + LOG2_N'(1);
            sum_q[c] <= win_sum[c];
          end
        end
        // A grant on the same edge frees the slot, so the new result is kept.
        if (close[c] && (!pend_q[c] || grant[c])) begin
          pend_q[c]     <= 1'b1;
          pend_avg_q[c] <= win_sum[c][SUM_W-1:LOG2_N];
        end else if (grant[c]) begin
          pend_q[c] <= 1'b0;
        end
        if (close[c] && pend_q[c] && !grant[c]) ovf_q[c] <= 1'b1;
      end
      if (slot_load) begin
        out_vld_q <= found;
        if (found) begin
          out_ch_q  <= gsel;
          out_avg_q <= pend_avg_q[gsel];
          rr_q      <= (gsel == 2'd2) ? 2'd0 : gsel + 2'd1;
        end
      end
    end
  end

`ifdef ROB_DUR_AVG_MAX_EN
  logic [DUR_W-1:0] max_q      [3];
  logic [DUR_W-1:0] win_max    [3];
  logic [DUR_W-1:0] pend_max_q [3];
  logic [DUR_W-1:0] out_max_q;

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      win_max[c] = (smp_dur[c] > max_q[c]) ? smp_dur[c] : max_q[c];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < 3; c++) begin
        max_q[c]      <= '0;
        pend_max_q[c] <= '0;
      end
      out_max_q <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (smp_vld[c]) max_q[c] <= close[c] ? '0 : win_max[c];
        if (close[c] && (!pend_q[c] || grant[c])) pend_max_q[c] <= win_max[c];
      end
      if (slot_load && found) out_max_q <= pend_max_q[gsel];
    end
  end

  assign out_max = out_max_q;
`else
  assign out_max = '0;
`endif

  assign out_vld = out_vld_q;
  assign out_ch  = out_ch_q;
  assign out_avg = out_avg_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_rob_dur_avg.sv
// Directed bench for rob_dur_avg with LOG2_N=2 (4-sample windows).
module tb_rob_dur_avg;
  localparam int unsigned W = 10;
  localparam int unsigned L = 2;
`ifdef ROB_DUR_AVG_MAX_EN
  localparam bit MaxEn = 1'b1;
`else
  localparam bit MaxEn = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [W-1:0] dur_dp, dur_fast, dur_slow;
  logic         dur_dp_vld, dur_fast_vld, dur_slow_vld;
  logic         out_vld, out_rdy;
  logic [1:0]   out_ch;
  logic [W-1:0] out_avg, out_max;
  logic [2:0]   ovf;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] dpv [4] = '{10'd1, 10'd2, 10'd3, 10'd6};
  logic [W-1:0] fv  [4] = '{10'd8, 10'd8, 10'd8, 10'd8};
  logic [W-1:0] sv  [4] = '{10'd100, 10'd0, 10'd0, 10'd0};
  logic [W-1:0] sim_avg [3] = '{10'd3, 10'd8, 10'd25};
  logic [W-1:0] sim_max [3] = '{10'd6, 10'd8, 10'd100};

  rob_dur_avg #(.DUR_W(W), .LOG2_N(L)) dut (
    .clk          (clk),
    .reset        (reset),
    .dur_dp       (dur_dp),
    .dur_dp_vld   (dur_dp_vld),
    .dur_fast     (dur_fast),
    .dur_fast_vld (dur_fast_vld),
    .dur_slow     (dur_slow),
    .dur_slow_vld (dur_slow_vld),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .out_ch       (out_ch),
    .out_avg      (out_avg),
    .out_max      (out_max),
    .ovf          (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [W-1:0] emax(input logic [W-1:0] m);
    return MaxEn ? m : '0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    dur_dp_vld = 1'b0; dur_fast_vld = 1'b0; dur_slow_vld = 1'b0;
    dur_dp = '0; dur_fast = '0; dur_slow = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic send_dp(input logic [W-1:0] v);
    dur_dp = v; dur_dp_vld = 1'b1;
    tick();
    dur_dp_vld = 1'b0;
  endtask

  task automatic send_fast(input logic [W-1:0] v);
    dur_fast = v; dur_fast_vld = 1'b1;
    tick();
    dur_fast_vld = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    out_rdy = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_vld: got %0b want 0", out_vld); end
    checks++; if (out_ch !== 2'd0) begin failures++; $display("FAIL reset_ch: got %0d want 0", out_ch); end
    checks++; if (out_avg !== '0) begin failures++; $display("FAIL reset_avg: got %0d want 0", out_avg); end
    checks++; if (out_max !== '0) begin failures++; $display("FAIL reset_max: got %0d want 0", out_max); end
    checks++; if (ovf !== 3'b000) begin failures++; $display("FAIL reset_ovf: got %b want 000", ovf); end
    reset = 1'b0;
  endtask

  task automatic test_basic_avg;
    out_rdy = 1'b1;
    send_dp(10'd10);
    dur_dp = 10'd1000;  // junk on the bus with vld low
    tick();
    send_dp(10'd20);
    send_dp(10'd30);
    send_dp(10'd40);
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL basic_early: got vld %0b want 0", out_vld); end
    tick();
    checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL basic_vld: got %0b want 1", out_vld); end
    checks++; if (out_ch !== 2'd0) begin failures++; $display("FAIL basic_ch: got %0d want 0", out_ch); end
    checks++; if (out_avg !== 10'd25) begin failures++; $display("FAIL basic_avg: got %0d want 25", out_avg); end
    checks++; if (out_max !== emax(10'd40)) begin failures++; $display("FAIL basic_max: got %0d want %0d", out_max, emax(10'd40)); end
    checks++; if (ovf !== 3'b000) begin failures++; $display("FAIL basic_ovf: got %b want 000", ovf); end
    tick();
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL basic_pop: got vld %0b want 0", out_vld); end
  endtask

  task automatic test_trunc_wide;
    out_rdy = 1'b1;
    send_fast(10'd1); send_fast(10'd2); send_fast(10'd2); send_fast(10'd2);
    tick();
    checks++; if (out_ch !== 2'd1) begin failures++; $display("FAIL trunc_ch: got %0d want 1", out_ch); end
    checks++; if (out_avg !== 10'd1) begin failures++; $display("FAIL trunc_avg: got %0d want 1", out_avg); end
    checks++; if (out_max !== emax(10'd2)) begin failures++; $display("FAIL trunc_max: got %0d want %0d", out_max, emax(10'd2)); end
    tick();
    for (int i = 0; i < 4; i++) send_fast(10'd1023);
    tick();
    checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL wide_vld: got %0b want 1", out_vld); end
    checks++; if (out_avg !== 10'd1023) begin failures++; $display("FAIL wide_avg: got %0d want 1023", out_avg); end
    checks++; if (out_max !== emax(10'd1023)) begin failures++; $display("FAIL wide_max: got %0d want %0d", out_max, emax(10'd1023)); end
    tick();
  endtask

  task automatic test_simultaneous;
    do_reset();
    out_rdy = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int s = 0; s < 4; s++) begin
        dur_dp = dpv[s]; dur_fast = fv[s]; dur_slow = sv[s];
        dur_dp_vld = 1'b1; dur_fast_vld = 1'b1; dur_slow_vld = 1'b1;
        tick();
      end
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
        tick();
        checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL sim_vld b%0d i%0d: got %0b want 1", b, i, out_vld); end
        checks++; if (out_ch !== 2'(i)) begin failures++; $display("FAIL sim_ch b%0d i%0d: got %0d want %0d", b, i, out_ch, i); end
        checks++; if (out_avg !== sim_avg[i]) begin failures++; $display("FAIL sim_avg b%0d i%0d: got %0d want %0d", b, i, out_avg, sim_avg[i]); end
        checks++; if (out_max !== emax(sim_max[i])) begin failures++; $display("FAIL sim_max b%0d i%0d: got %0d want %0d", b, i, out_max, emax(sim_max[i])); end
      end
      tick();
      checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL sim_drain b%0d: got vld %0b want 0", b, out_vld); end
    end
  endtask

  task automatic test_backpressure;
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_dp(10'd5);
    for (int i = 0; i < 4; i++) send_dp(10'd9);
    checks++; if (ovf !== 3'b000) begin failures++; $display("FAIL bp_no_ovf: got %b want 000", ovf); end
    for (int i = 0; i < 4; i++) send_dp(10'd1);
    checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL bp_hold_vld: got %0b want 1", out_vld); end
    checks++; if (out_avg !== 10'd5) begin failures++; $display("FAIL bp_hold_avg: got %0d want 5", out_avg); end
    checks++; if (ovf !== 3'b001) begin failures++; $display("FAIL bp_ovf: got %b want 001", ovf); end
    out_rdy = 1'b1;
    tick();
    checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL bp_second_vld: got %0b want 1", out_vld); end
    checks++; if (out_avg !== 10'd9) begin failures++; $display("FAIL bp_second_avg: got %0d want 9", out_avg); end
    checks++; if (out_max !== emax(10'd9)) begin failures++; $display("FAIL bp_second_max: got %0d want %0d", out_max, emax(10'd9)); end
    tick();
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL bp_lost: got vld %0b want 0", out_vld); end
    checks++; if (ovf !== 3'b001) begin failures++; $display("FAIL bp_ovf_sticky: got %b want 001", ovf); end
  endtask

  task automatic test_reset_midwindow;
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) send_dp(10'd50);
    do_reset();
    checks++; if (ovf !== 3'b000) begin failures++; $display("FAIL mid_ovf: got %b want 000", ovf); end
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL mid_vld: got %0b want 0", out_vld); end
    for (int i = 0; i < 3; i++) send_dp(10'd8);
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL mid_partial: got vld %0b want 0", out_vld); end
    send_dp(10'd8);
    tick();
    checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL mid_res_vld: got %0b want 1", out_vld); end
    checks++; if (out_avg !== 10'd8) begin failures++; $display("FAIL mid_res_avg: got %0d want 8", out_avg); end
    tick();
  endtask

  task automatic test_hold_stable;
    logic [W+W+2:0] exp_bus;
    out_rdy = 1'b0;
    send_fast(10'd10); send_fast(10'd20); send_fast(10'd30); send_fast(10'd40);
    tick();
    exp_bus = {1'b1, 2'd1, 10'd25, emax(10'd40)};
    for (int i = 0; i < 10; i++) begin
      send_fast(10'd1000);
      checks++;
      if ({out_vld, out_ch, out_avg, out_max} !== exp_bus) begin
        failures++;
        $display("FAIL hold_stable cyc%0d: got vld=%0b ch=%0d avg=%0d max=%0d want vld=1 ch=1 avg=25 max=%0d",
                 i, out_vld, out_ch, out_avg, out_max, emax(10'd40));
      end
    end
    out_rdy = 1'b1;
    tick();
    checks++; if (out_ch !== 2'd1) begin failures++; $display("FAIL hold_next_ch: got %0d want 1", out_ch); end
    checks++; if (out_avg !== 10'd1000) begin failures++; $display("FAIL hold_next_avg: got %0d want 1000", out_avg); end
    checks++; if (out_max !== emax(10'd1000)) begin failures++; $display("FAIL hold_next_max: got %0d want %0d", out_max, emax(10'd1000)); end
    tick();
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL hold_drain: got vld %0b want 0", out_vld); end
    checks++; if (ovf !== 3'b010) begin failures++; $display("FAIL hold_ovf: got %b want 010", ovf); end
  endtask

  initial begin
    reset = 1'b1;
    out_rdy = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_avg();
    test_trunc_wide();
    test_simultaneous();
    test_backpressure();
    test_reset_midwindow();
    test_hold_stable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rob_dur_avg.md
# rob_dur_avg

- Consumer of the per-instruction ROB residency samples produced by the avfcl ROB duration monitor.
- Accumulates dispatch-to-retire, fast writeback-to-retire and slow writeback-to-retire duration samples over fixed windows of 2^LOG2_N samples per channel.
- At the end of each window it computes the channel mean (and, optionally, the window maximum).
- Results go out one at a time on a ready/valid port to the AVF estimation logic.

## Interface
Parameters:
- DUR_W, 10, width of each duration sample and of each result
- LOG2_N, 4, log2 of samples per window; N = 2^LOG2_N

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- dur_dp  in  DUR_W  dispatch-to-retire duration sample
- dur_dp_vld  in  1  dur_dp valid this cycle
- dur_fast  in  DUR_W  fast-writeback duration sample
- dur_fast_vld  in  1  dur_fast valid this cycle
- dur_slow  in  DUR_W  slow-writeback duration sample
- dur_slow_vld  in  1  dur_slow valid this cycle
- out_vld  out  1  result valid
- out_rdy  in  1  downstream accepts result
- out_ch  out  2  result channel: 0 = dp, 1 = fast, 2 = slow
- out_avg  out  DUR_W  window mean
- out_max  out  DUR_W  window maximum; 0 when the max feature is compiled out
- ovf  out  3  sticky per-channel drop flag; bit order dp, fast, slow

## Operation
Per channel c (independent; all three may take a sample in the same cycle):
- Registers:
  - cnt[c]: LOG2_N bits
  - sum[c]: DUR_W+LOG2_N bits, so it never overflows
  - max[c]: DUR_W bits
  - pend[c]: flag plus avg/max payload
- Sample accepted on any edge where the channel's vld is high.
- If cnt[c] < N-1: sum += dur, cnt += 1, max = max(max, dur).
- If cnt[c] == N-1 (Nth sample), the window closes on the same edge:
  - avg = (sum + dur) >> LOG2_N, truncating.
  - Window max = max(max, dur).
  - If the pend slot is free, or is being emptied on this edge, load pend[c] with avg/max and set the flag.
  - Otherwise drop the result and set ovf[c]. It stays set until reset.
  - In both cases, sum, cnt and max are cleared and the next window starts with the following sample.

Output stage:
- A single registered slot drives out_vld, out_ch, out_avg and out_max.
- The slot loads when it is empty, or when out_vld && out_rdy on this edge.
- Source is the pending channel chosen round-robin: the search starts at the channel after the last granted one, order dp→fast→slow→dp.
- After the pointer reaches slow it returns to dp (2→0); value 3 is never used.
- Loading from channel c clears pend[c] on the same edge.
- out_vld holds, with the payload stable, until out_rdy is sampled high.

## Timing
- Reset values:
  - out_vld = 0, out_ch = 0, out_avg = 0, out_max = 0, ovf = 0
  - all cnt, sum, max and pend flags = 0
  - round-robin pointer = 0, so dp has first priority
- Latency: Nth sample on edge T sets pend at T. out_vld is high after edge T+1 when the slot is free or popping at T+1.
- Throughput: one result per cycle while out_rdy is held high.
- Simultaneous window close on pend[c] and grant of channel c on the same edge: the new result is kept in pend[c], not dropped.
- A window close when the slot is full and pend[c] is set, with no grant to c, is a drop and sets ovf[c].
- Reset mid-window or while out_vld is high discards all partial sums and pending results. No result is emitted after reset until a fresh N samples have arrived.
- A dur value is not sampled when its vld is low, whatever is on the data bus.

## Configuration
- ROB_DUR_AVG_MAX_EN defined:
  - max[c] registers and the pend max payloads are built.
  - out_max carries the window maximum.
- ROB_DUR_AVG_MAX_EN undefined:
  - no max storage is built.
  - out_max is constant 0.
  - all other behaviour is identical.

## Test plan
- LOG2_N=2, dp samples 10, 20, 30, 40 on consecutive cycles, out_rdy=1 → one result: out_ch=0, out_avg=25, out_max=40 (0 if compiled out), ovf=0.
- Fast samples 1, 2, 2, 2 → out_avg=1 (truncation from 7/4); then 1023 ×4 → out_avg=1023, proving no sum overflow.
- All three channels close on the same edge, out_rdy=1 → results on consecutive cycles with out_ch 0, 1, 2. A second identical burst → again 0, 1, 2, since the pointer is back at dp after the 2→0 step.
- out_rdy=0, dp completes two windows (avg 5, then avg 9) → first result stays held on out_vld with avg 5, second sits in pend. A third window → ovf[0]=1 and its result is lost; raising out_rdy yields avg 5, then avg 9.
- Reset asserted after 3 of 4 dp samples → no output. The next 4 samples 8, 8, 8, 8 → out_avg=8.
- out_vld held with out_rdy=0 for 10 cycles while new fast samples arrive → out_ch, out_avg and out_max remain stable until the rdy handshake.
